// File: rtl/calc_adder_arbiter.sv
// -----------------------------------------------------------------------------
// calc_adder_arbiter
//
// Round-robin scheduler that shares one multi-cycle adder (4-bit operands,
// 8-bit sign-extended sum, start/done handshake) between two requesters of
// the calculator datapath. Operands of the granted requester are captured at
// the handshake, a one-cycle start pulse is issued, and the adder's sum is
// returned to the owner as a one-cycle response pulse. A watchdog aborts the
// operation with rsp_err if the adder never reports done.
//
// Ports
//   clk, rst                 clock (posedge), synchronous active-high reset
//   req0_valid/a/b, req0_ready   requester 0 request channel
//   req1_valid/a/b, req1_ready   requester 1 request channel
//   rsp0_valid, rsp1_valid   one-cycle response pulses per requester
//   rsp_sum, rsp_err         shared response payload (err = timeout)
//   adder_start/a/b          command to the shared adder
//   adder_done, adder_sum    result from the shared adder
//   busy                     high whenever the scheduler is not idle
//   grant_id                 requester owning the current or last operation
// -----------------------------------------------------------------------------
module calc_adder_arbiter #(
   parameter int TIMEOUT = 8,
   parameter int CW      = 8
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_valid,
   input  logic [3:0]  req0_a,
   input  logic [3:0]  req0_b,
   output logic        req0_ready,
   output logic        rsp0_valid,

   input  logic        req1_valid,
   input  logic [3:0]  req1_a,
   input  logic [3:0]  req1_b,
   output logic        req1_ready,
   output logic        rsp1_valid,

   output logic [7:0]  rsp_sum,
   output logic        rsp_err,

   output logic        adder_start,
   output logic [3:0]  adder_a,
   output logic [3:0]  adder_b,
   input  logic        adder_done,
   input  logic [7:0]  adder_sum,

   output logic        busy,
   output logic        grant_id
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   state_t          state_q;
   logic            last_grant_q;
   logic            grant_id_q;
   logic            adder_start_q;
   logic [3:0]      adder_a_q;
   logic [3:0]      adder_b_q;
   logic            rsp0_valid_q;
   logic            rsp1_valid_q;
   logic [7:0]      rsp_sum_q;
   logic            rsp_err_q;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   cnt_d;

   logic            gnt_sel;
   logic            idle_open;
   logic            xfer;

   // On a tie the requester that did not own the last operation wins;
   // otherwise the single valid requester is selected.
   always_comb begin
      gnt_sel    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
      idle_open  = (state_q == S_IDLE) && !rst;
      req0_ready = idle_open && req0_valid && !gnt_sel;
      req1_ready = idle_open && req1_valid &&  gnt_sel;
      xfer       = req0_ready || req1_ready;
      cnt_d      = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         last_grant_q  <= 1'b1;
         grant_id_q    <= 1'b0;
         adder_start_q <= 1'b0;
         adder_a_q     <= '0;
         adder_b_q     <= '0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;
         rsp_sum_q     <= '0;
         rsp_err_q     <= 1'b0;
         cnt_q         <= '0;
      end else begin
         // Pulse outputs default low; they are raised for exactly one cycle.
         adder_start_q <= 1'b0;
         rsp0_valid_q  <= 1'b0;
         rsp1_valid_q  <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (xfer) begin
                  adder_a_q     <= gnt_sel ? req1_a : req0_a;
                  adder_b_q     <= gnt_sel ? req1_b : req0_b;
                  grant_id_q    <= gnt_sel;
                  last_grant_q  <= gnt_sel;
                  adder_start_q <= 1'b1;
                  state_q       <= S_ISSUE;
               end
            end

            // adder_start is high during this state; any done level seen
            // here belongs to the previous operation and is ignored.
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end

            S_WAIT: begin
               if (adder_done) begin
                  rsp_sum_q    <= adder_sum;
                  rsp_err_q    <= 1'b0;
                  rsp0_valid_q <= ~grant_id_q;
                  rsp1_valid_q <=  grant_id_q;
                  state_q      <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_sum_q    <= '0;
                  rsp_err_q    <= 1'b1;
                  rsp0_valid_q <= ~grant_id_q;
                  rsp1_valid_q <=  grant_id_q;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            // Response pulse is visible during this state; no request is
            // accepted until the return to IDLE.
            S_RESP: begin
               state_q <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp0_valid  = rsp0_valid_q;
   assign rsp1_valid  = rsp1_valid_q;
   assign rsp_sum     = rsp_sum_q;
   assign rsp_err     = rsp_err_q;
   assign adder_start = adder_start_q;
   assign adder_a     = adder_a_q;
   assign adder_b     = adder_b_q;
   assign busy        = (state_q != S_IDLE);
   assign grant_id    = grant_id_q;

endmodule

// File: doc/calc_adder_arbiter.md
Name: calc_adder_arbiter

Overview:
- Round-robin scheduler that shares one multi-cycle adder unit (4-bit operands, 8-bit sign-extended sum, start/done handshake) between two requesters in the calculator datapath.
- Captures operands from the granted requester and issues a one-cycle start pulse to the adder.
- Holds the operands stable until the adder's done, then returns the sum to that requester as a one-cycle response pulse.
- Includes a watchdog timeout so a hung adder cannot lock the calculator.

Parameters:
- TIMEOUT, 8, number of WAIT cycles without adder_done before the operation aborts with an error (valid range 4..255).
- CW, 8, width of the internal timeout counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- req0_valid  input  1  requester 0 has an operation pending; held high until accepted.
- req0_a  input  4  requester 0 operand A (two's complement).
- req0_b  input  4  requester 0 operand B.
- req0_ready  output  1  combinational; high in IDLE when requester 0 is the granted requester.
- rsp0_valid  output  1  registered one-cycle pulse; result for requester 0.
- req1_valid, req1_a, req1_b, req1_ready, rsp1_valid: same as requester 0, for requester 1.
- rsp_sum  output  8  result; meaningful only while rsp0_valid or rsp1_valid is high.
- rsp_err  output  1  qualifies rsp_sum; high means timeout.
- adder_start  output  1  registered one-cycle start pulse to the adder.
- adder_a  output  4  registered operand A; stable from ISSUE until the FSM leaves WAIT.
- adder_b  output  4  registered operand B; same stability rule.
- adder_done  input  1  adder done level; may still be high from the previous operation.
- adder_sum  input  8  adder result; valid while adder_done is high.
- busy  output  1  high in any state except IDLE.
- grant_id  output  1  requester owning the current or last operation.

Behaviour:
- Reset:
  - state=IDLE.
  - adder_start, adder_a, adder_b, rsp0_valid, rsp1_valid, rsp_sum, rsp_err, busy, grant_id all 0.
  - last_grant=1, so req0 wins the first tie.
  - readies are 0 while rst is high.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant logic: only one requester valid → it is granted; both valid → the requester != last_grant is granted.
  - Only the granted requester's ready is high. Transfer occurs when valid & ready.
  - On transfer: capture operands into adder_a/adder_b, set grant_id and last_grant, go to ISSUE.
  - No valid → remain in IDLE.
- ISSUE: adder_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - adder_done is sampled only here. A done level present during ISSUE is stale and is ignored.
  - On adder_done=1: latch rsp_sum=adder_sum, rsp_err=0, go to RESP.
  - Otherwise increment the counter. When counter==TIMEOUT-1 and done is still low: rsp_sum=0, rsp_err=1, go to RESP.
- RESP:
  - rsp{grant_id}_valid=1 for this single cycle.
  - rsp_sum and rsp_err hold their values until the next response.
  - Go to IDLE.
  - No request is accepted in RESP.
- Latency:
  - Handshake at cycle T → adder_start at T+1.
  - With the standard 3-cycle adder, done is seen at T+5 and rsp pulse occurs at T+6.
  - Next acceptance possible at T+7.
- Arithmetic: none in the arbiter; adder_sum is passed through unmodified, including the adder's 8-bit sign extension.
- Requester inputs changing while not granted or while busy: ignored; operands are captured only at handshake.
- Reset mid-operation (any state): immediate return to reset values. An in-flight operation is dropped with no response. The adder is reset by the same rst.
- Simultaneous new request during RESP: held off until IDLE, then arbitrated normally.

Test Plan:
- Single request: req0 a=4'h3, b=4'h2 at T; stub adder with 3-cycle latency → adder_start at T+1, rsp0_valid at T+6 with rsp_sum=8'h05, rsp_err=0; rsp1_valid stays 0.
- Negative operands: req1 a=4'hD, b=4'hE → rsp1_valid, rsp_sum=8'hFB, rsp_err=0.
- Tie and rotation: both valid from reset → req0 served first, then req1, then req0 again; grant_id sequence 0,1,0; each response matches its own operands.
- Stale done: stub adder holds done=1 from the prior op through ISSUE and drops it the next cycle → no early response; rsp pulse only after the new done.
- Timeout: stub never asserts done → rsp0_valid exactly TIMEOUT WAIT cycles after ISSUE with rsp_err=1, rsp_sum=0; the next request completes normally.
- Reset in WAIT: assert rst for 1 cycle two cycles after adder_start → no rsp pulse, all outputs 0, busy=0; a following req0 tie wins.
